// File: rtl/sensor_monitor.sv
// sensor_monitor
//   Debounced fault detector for a 4-bit sensor vector. An error term derived
//   from the sensors must stay asserted for DEBOUNCE_CYCLES consecutive clocks
//   before a fault is declared. A declared fault latches until the host
//   acknowledges it. After that, the sensors must show one clean cycle before
//   a new qualification can begin.
//
//   Optional feature: define SENSOR_MONITOR_COUNT_EN to build the saturating
//   fault counter. Without it, fault_count is tied to zero.
//
//   Ports
//     clk          system clock, rising edge
//     n_rst        asynchronous active-low reset
//     sensors[3:0] raw sensor vector, synchronous to clk
//     ack          host fault acknowledge (level); honoured only in FAULT
//     fault        latched fault flag
//     irq          one-cycle pulse on fault declaration
//     fault_code   sensor snapshot from the declaring cycle
//     fault_count  saturating count of declared faults
module sensor_monitor #(
    parameter int DEBOUNCE_CYCLES = 4   // legal 1..15
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] sensors,
    input  logic       ack,
    output logic       fault,
    output logic       irq,
    output logic [3:0] fault_code,
    output logic [7:0] fault_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        FAULT   = 2'd2,
        REARM   = 2'd3
    } state_e;

    // The qualify counter holds the number of error edges seen so far.
    // The declaring edge is the one where this count reaches DEBOUNCE_CYCLES-1.
    localparam logic [3:0] QUAL_LAST = 4'(DEBOUNCE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] qual_q,  qual_d;
    logic       fault_q, fault_d;
    logic       irq_q,   irq_d;
    logic [3:0] code_q,  code_d;
    logic       raw_err;
    logic       declare;

    assign raw_err = sensors[0] | (sensors[1] & (sensors[2] | sensors[3]));

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        declare = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (raw_err) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = FAULT;
                        declare = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                        qual_d  = 4'd1;
                    end
                end
            end
            QUALIFY: begin
                if (!raw_err) begin
                    state_d = IDLE;
                    qual_d  = 4'd0;
                end else if (qual_q == QUAL_LAST) begin
                    state_d = FAULT;
                    qual_d  = 4'd0;
                    declare = 1'b1;
                end else begin
                    qual_d  = qual_q + 4'd1;
                end
            end
            FAULT: begin
                // Sensors are ignored here. Only an ack seen while already
                // in FAULT releases the fault, so an ack that coincides with
                // the declaring edge has no effect.
                if (ack) state_d = REARM;
            end
            REARM: begin
                if (!raw_err) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                qual_d  = 4'd0;
            end
        endcase
    end

    // The fault flag mirrors residency in FAULT.
    // irq is driven only by the declaring transition. Because FAULT cannot
    // declare again, irq can never stay high on two consecutive cycles.
    always_comb begin
        fault_d = (state_d == FAULT);
        irq_d   = declare;
        code_d  = declare ? sensors : code_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            qual_q  <= 4'd0;
            fault_q <= 1'b0;
            irq_q   <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            fault_q <= fault_d;
            irq_q   <= irq_d;
            code_q  <= code_d;
        end
    end

`ifdef SENSOR_MONITOR_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (declare && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= 8'h00;
        else        count_q <= count_d;
    end

    assign fault_count = count_q;
`else
    assign fault_count = 8'h00;
`endif

    assign fault      = fault_q;
    assign irq        = irq_q;
    assign fault_code = code_q;

endmodule

// File: doc/sensor_monitor.md
SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive error samples required to declare a fault; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 sensors  input  4  raw sensor vector; synchronous to clk.
REQ-005 ack  input  1  host fault acknowledge; level, sampled on rising edge of clk.
REQ-006 fault  output  1  latched fault flag; high from fault declaration until ack accepted.
REQ-007 irq  output  1  single-cycle pulse on fault declaration.
REQ-008 fault_code  output  4  sensors snapshot taken in the declaring cycle.
REQ-009 fault_count  output  8  count of declared faults, saturating.

Function
REQ-010 Raw error term SHALL be raw_err = sensors[0] | (sensors[1] & (sensors[2] | sensors[3])), evaluated combinationally each cycle.
REQ-011 FSM SHALL have four states: IDLE, QUALIFY, FAULT, REARM.
REQ-012 IDLE: raw_err=1 -> QUALIFY with 4-bit qual counter = 1; if DEBOUNCE_CYCLES=1, go directly to FAULT instead.
REQ-013 QUALIFY: raw_err=0 -> IDLE, counter cleared; raw_err=1 and counter = DEBOUNCE_CYCLES-1 -> FAULT; else counter +1.
REQ-014 Latency: fault and irq SHALL go high immediately after the DEBOUNCE_CYCLES-th consecutive rising edge with raw_err=1.
REQ-015 On the IDLE/QUALIFY -> FAULT transition: fault <= 1, irq <= 1 for exactly one cycle, fault_code <= sensors in that cycle, fault_count increments.
REQ-016 fault_count SHALL saturate at 255 and never wrap.
REQ-017 FAULT: ack=1 -> REARM with fault <= 0; ack=0 -> remain, fault held high; raw_err changes in FAULT are ignored.
REQ-018 REARM: raw_err=0 -> IDLE; raw_err=1 -> remain; no new fault may be declared until one cycle with raw_err=0 has been seen.
REQ-019 ack SHALL be ignored in IDLE, QUALIFY and REARM.
REQ-020 ack high in the same cycle the FSM enters FAULT SHALL NOT be accepted; acceptance requires ack high while already in FAULT.
REQ-021 fault_code SHALL hold its value until the next fault declaration or reset.
REQ-022 irq SHALL never be high for two consecutive cycles.

Reset
REQ-023 n_rst low SHALL immediately force: state IDLE, qual counter 0, fault 0, irq 0, fault_code 4'h0, fault_count 8'h00.
REQ-024 Reset asserted mid-QUALIFY or in FAULT SHALL discard all progress; after release, qualification restarts from IDLE.

Configuration
REQ-025 Macro SENSOR_MONITOR_COUNT_EN defined: fault_count register implemented per REQ-015/016.
REQ-026 Macro SENSOR_MONITOR_COUNT_EN undefined: no counter register; fault_count tied to 8'h00; all other behaviour identical.

Verification
REQ-027 DEBOUNCE_CYCLES=4, sensors=4'b0001 held 4 cycles -> fault=1 and irq pulse after 4th edge, fault_code=4'h1, fault_count=1.
REQ-028 sensors=4'b0110 for 3 cycles then 4'b0000 -> no fault, no irq, FSM back to IDLE, counter 0.
REQ-029 Fault held, ack=1 one cycle while sensors=4'b1010 persists -> fault=0, no new irq until sensors=4'b0000 one cycle then 4 more error cycles.
REQ-030 n_rst pulsed low during QUALIFY (count=3) and during FAULT -> all outputs 0 immediately; fresh 4-cycle qualification required.
REQ-031 256 fault/ack/re-arm cycles with SENSOR_MONITOR_COUNT_EN defined -> fault_count=255 saturated; undefined build -> fault_count=0 throughout.
REQ-032 DEBOUNCE_CYCLES=1, sensors=4'b0011 one cycle -> fault and irq after first edge, fault_code=4'h3.
